// File: rtl/cachepkg.sv
// Shared cache-side types: memory operation codes and write-buffer FSM states.
// Pure declarations, no logic.
package cachepkg;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } op_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACK       = 3'd1,
    READ_MISS = 3'd2,
    DRAIN     = 3'd3,
    FLUSH_ACK = 3'd4
  } wb_state_t;

endpackage

// File: rtl/wb_store.sv
// Write-buffer line store: circular FIFO of {valid, line tag, data} with a parallel tag match.
// Push/coalesce/pop take effect on the next edge; match and head outputs are combinational.
module wb_store #(
  parameter int DEPTH    = 4,
  parameter int ADDRBITS = 32,
  parameter int LINEBITS = 512,
  localparam int OFFBITS = $clog2(LINEBITS / 8),
  localparam int TAGBITS = ADDRBITS - OFFBITS,
  localparam int PTRW    = $clog2(DEPTH),
  localparam int CNTW    = PTRW + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [TAGBITS-1:0]  tag_i,
  input  logic [LINEBITS-1:0] wdata_i,
  input  logic                push_i,
  input  logic                coalesce_i,
  input  logic                pop_i,
  output logic                hit_o,
  output logic [LINEBITS-1:0] hit_data_o,
  output logic [TAGBITS-1:0]  head_tag_o,
  output logic [LINEBITS-1:0] head_data_o,
  output logic [CNTW-1:0]     count_o,
  output logic                full_o
);

  logic [DEPTH-1:0]    valid_q;
  logic [TAGBITS-1:0]  tag_q  [DEPTH];
  logic [LINEBITS-1:0] data_q [DEPTH];
  logic [PTRW-1:0]     head_q, head_d;
  logic [PTRW-1:0]     tail_q, tail_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [PTRW-1:0]     hit_idx;

  // Coalescing keeps each line in at most one entry, so the first match is the only one.
  always_comb begin
    hit_o   = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit_o && valid_q[i] && (tag_q[i] == tag_i)) begin
        hit_o   = 1'b1;
        hit_idx = PTRW'(i);
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) begin
      tail_d  = tail_q + 1'b1;
      count_d = count_q + 1'b1;
    end
    if (pop_i) begin
      head_d  = head_q + 1'b1;
      count_d = count_d - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) valid_q[tail_q] <= 1'b1;
      if (pop_i)  valid_q[head_q] <= 1'b0;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Tag and line storage are qualified by valid_q, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      tag_q[tail_q]  <= tag_i;
      data_q[tail_q] <= wdata_i;
    end else if (coalesce_i) begin
      data_q[hit_idx] <= wdata_i;
    end
  end

  assign hit_data_o  = data_q[hit_idx];
  assign head_tag_o  = tag_q[head_q];
  assign head_data_o = data_q[head_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == CNTW'(DEPTH));

endmodule

// File: rtl/write_buffer.sv
// Writeback buffer between cache and memory: coalesces line writes, forwards read hits, drains FIFO-order.
// up_valid one cycle after the request is taken in IDLE (or after dn_valid on a miss); waits on dn_valid.
module write_buffer
  import cachepkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDRBITS = 32,
  parameter int LINEBITS = 512,
  localparam int OFFBITS = $clog2(LINEBITS / 8),
  localparam int TAGBITS = ADDRBITS - OFFBITS,
  localparam int CNTW    = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                up_request,
  input  op_t                 up_operation,
  input  logic [ADDRBITS-1:0] up_addr,
  input  logic [LINEBITS-1:0] up_wdata,
  output logic [LINEBITS-1:0] up_rdata,
  output logic                up_valid,
  input  logic                up_flush,
  output logic                up_flush_done,
  output logic                dn_request,
  output op_t                 dn_operation,
  output logic [ADDRBITS-1:0] dn_addr,
  output logic [LINEBITS-1:0] dn_wdata,
  input  logic [LINEBITS-1:0] dn_rdata,
  input  logic                dn_valid
);

  wb_state_t           state_q;
  logic [LINEBITS-1:0] up_rdata_q;
  logic                up_valid_q;
  logic                up_flush_done_q;
  logic                dn_request_q;
  op_t                 dn_operation_q;

  logic                hit;
  logic                full;
  logic [LINEBITS-1:0] hit_data;
  logic [TAGBITS-1:0]  head_tag;
  logic [LINEBITS-1:0] head_data;
  logic [CNTW-1:0]     count;
  logic                req_write;
  logic                push;
  logic                coalesce;
  logic                pop;
  logic                unused_offset;

  assign unused_offset = ^up_addr[OFFBITS-1:0];

  assign req_write = (state_q == IDLE) && up_request && (up_operation == WRITE);
  assign push      = req_write && !hit && !full;
  assign coalesce  = req_write && hit;
  assign pop       = (state_q == DRAIN) && dn_request_q && dn_valid;

  wb_store #(
    .DEPTH    (DEPTH),
    .ADDRBITS (ADDRBITS),
    .LINEBITS (LINEBITS)
  ) u_store (
    .clk_i       (clock),
    .rst_ni      (reset),
    .tag_i       (up_addr[ADDRBITS-1:OFFBITS]),
    .wdata_i     (up_wdata),
    .push_i      (push),
    .coalesce_i  (coalesce),
    .pop_i       (pop),
    .hit_o       (hit),
    .hit_data_o  (hit_data),
    .head_tag_o  (head_tag),
    .head_data_o (head_data),
    .count_o     (count),
    .full_o      (full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      up_rdata_q      <= '0;
      up_valid_q      <= 1'b0;
      up_flush_done_q <= 1'b0;
      dn_request_q    <= 1'b0;
      dn_operation_q  <= NOP;
    end else begin
      up_valid_q      <= 1'b0;
      up_flush_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (up_request && up_operation == WRITE) begin
            if (hit || !full) begin
              state_q    <= ACK;
              up_valid_q <= 1'b1;
            end else begin
              // Full: free the oldest line, the held write is taken on return to IDLE.
              state_q        <= DRAIN;
              dn_request_q   <= 1'b1;
              dn_operation_q <= WRITE;
            end
          end else if (up_request && up_operation == READ) begin
            if (hit) begin
              state_q    <= ACK;
              up_rdata_q <= hit_data;
              up_valid_q <= 1'b1;
            end else begin
              state_q        <= READ_MISS;
              dn_request_q   <= 1'b1;
              dn_operation_q <= READ;
            end
          end else if (up_flush && count == '0) begin
            state_q         <= FLUSH_ACK;
            up_flush_done_q <= 1'b1;
          end else if (count != '0) begin
            state_q        <= DRAIN;
            dn_request_q   <= 1'b1;
            dn_operation_q <= WRITE;
          end
        end
        ACK: state_q <= IDLE;
        READ_MISS: begin
          if (dn_valid) begin
            state_q        <= ACK;
            up_rdata_q     <= dn_rdata;
            up_valid_q     <= 1'b1;
            dn_request_q   <= 1'b0;
            dn_operation_q <= NOP;
          end
        end
        DRAIN: begin
          if (dn_valid && !(up_flush && count > CNTW'(1))) begin
            state_q        <= IDLE;
            dn_request_q   <= 1'b0;
            dn_operation_q <= NOP;
          end
        end
        FLUSH_ACK: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    dn_addr  = '0;
    dn_wdata = '0;
    if (state_q == DRAIN) begin
      dn_addr  = {head_tag, {OFFBITS{1'b0}}};
      dn_wdata = head_data;
    end else if (state_q == READ_MISS) begin
      dn_addr = {up_addr[ADDRBITS-1:OFFBITS], {OFFBITS{1'b0}}};
    end
  end

  assign up_rdata      = up_rdata_q;
  assign up_valid      = up_valid_q;
  assign up_flush_done = up_flush_done_q;
  assign dn_request    = dn_request_q;
  assign dn_operation  = dn_operation_q;

endmodule
